// File: rtl/disp_select_scan_pkg.sv
// Shared constants and the one-hot select decode for the display selector.
package disp_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_AUTO   = 1'b1;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_NCH   = 5;
   localparam int DEF_DWELL = 50000000;

   // An empty or multi-hot select falls back to channel 0.
   function automatic logic [4:0] onehot_to_idx(input logic [31:0] v);
      logic [4:0] idx;
      int         n;
      idx = '0;
      n   = 0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) begin
            idx = 5'(i);
            n++;
         end
      end
      return (n == 1) ? idx : 5'd0;
   endfunction

endpackage

// File: rtl/disp_select_scan_if.sv
// Control and data bundle between a debug source and the display selector.
// SNAP exists only when DISP_SNAPSHOT_EN is defined.
interface disp_select_scan_if #(
   parameter int WIDTH = 32,
   parameter int NCH   = 5,
   parameter int CW    = $clog2(NCH)
);
`ifdef DISP_SNAPSHOT_EN
   logic                  SNAP;
`endif
   logic [NCH-1:0]        SLCT;
   logic                  MODE;
   logic                  HOLD;
   logic [NCH*WIDTH-1:0]  DIN;
   logic [WIDTH-1:0]      Result;
   logic [CW-1:0]         CH;
   logic                  Update;

   modport master (
`ifdef DISP_SNAPSHOT_EN
      output SNAP,
`endif
      output SLCT, output MODE, output HOLD, output DIN,
      input  Result, input CH, input Update
   );

   modport slave (
`ifdef DISP_SNAPSHOT_EN
      input  SNAP,
`endif
      input  SLCT, input MODE, input HOLD, input DIN,
      output Result, output CH, output Update
   );
endinterface

// File: rtl/disp_select_scan_timer.sv
// Dwell counter and channel index register with wrap; load forces a manual index.
module disp_scan_timer #(
   parameter int NCH   = 5,
   parameter int DWELL = 4,
   parameter int CW    = $clog2(NCH)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          en,
   input  logic          clr,
   input  logic          load,
   input  logic [CW-1:0] load_idx,
   output logic [CW-1:0] ch,
   output logic [CW-1:0] ch_nxt
);
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      ch_nxt  = ch;
      if (load)
         ch_nxt = load_idx;
      if (clr) begin
         cnt_nxt = '0;
      end else if (en) begin
         if (cnt == LAST) begin
            cnt_nxt = '0;
            ch_nxt  = (ch == CW'(NCH - 1)) ? '0 : ch + CW'(1);
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt <= '0;
         ch  <= '0;
      end else begin
         cnt <= cnt_nxt;
         ch  <= ch_nxt;
      end
   end
endmodule

// File: rtl/disp_select_scan.sv
// Registered debug-channel display selector: manual one-hot select or timed auto-scan,
// with hold and change strobe. DISP_SNAPSHOT_EN adds a SNAP-loaded shadow bank.
module disp_select_scan
   import disp_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NCH   = DEF_NCH,
   parameter int DWELL = DEF_DWELL,
   localparam int CW   = $clog2(NCH)
) (
   input  logic                CLK,
   input  logic                RST,
   disp_select_scan_if.slave   bus
);
   logic [CW-1:0]        sel_idx;
   logic [CW-1:0]        ch;
   logic [CW-1:0]        ch_nxt;
   logic                 auto;
   logic [NCH*WIDTH-1:0] src;
   logic [WIDTH-1:0]     chan [NCH];
   logic [WIDTH-1:0]     result;
   logic                 update;

   assign sel_idx = CW'(onehot_to_idx(32'(bus.SLCT)));
   assign auto    = (bus.MODE == MODE_AUTO);

   disp_scan_timer #(.NCH(NCH), .DWELL(DWELL), .CW(CW)) u_timer (
      .CLK      (CLK),
      .RST      (RST),
      .en       (auto && !bus.HOLD),
      .clr      (!auto && !bus.HOLD),
      .load     (!auto && !bus.HOLD),
      .load_idx (sel_idx),
      .ch       (ch),
      .ch_nxt   (ch_nxt)
   );

`ifdef DISP_SNAPSHOT_EN
   logic [NCH*WIDTH-1:0] shadow;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         shadow <= '0;
      else if (bus.SNAP && !bus.HOLD)
         shadow <= bus.DIN;
   end

   // On the capture edge show the freshly captured value, not the stale shadow.
   assign src = (bus.SNAP && !bus.HOLD) ? bus.DIN : shadow;
`else
   assign src = bus.DIN;
`endif

   always_comb begin
      for (int i = 0; i < NCH; i++)
         chan[i] = src[i*WIDTH +: WIDTH];
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         result <= '0;
         update <= 1'b0;
      end else begin
         update <= (ch_nxt != ch);
         if (!bus.HOLD)
            result <= chan[ch_nxt];
      end
   end

   assign bus.Result = result;
   assign bus.CH     = ch;
   assign bus.Update = update;
endmodule

// File: tb/tb_disp_select_scan.sv
// Self-checking bench for disp_select_scan: directed steps plus randomized cycles
// against a cycle-level behavioural model of the selector.
module tb_disp_select_scan;
   localparam int WIDTH = 32;
   localparam int NCH   = 5;
   localparam int DWELL = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;

   int          m_ch;
   int          m_cnt;
   logic [31:0] m_res;
   logic        m_upd;

   disp_select_scan_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

   disp_select_scan #(.WIDTH(WIDTH), .NCH(NCH), .DWELL(DWELL)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] chan_of(input int idx);
      logic [NCH*WIDTH-1:0] d;
      d = bus.DIN;
      return d[idx*WIDTH +: WIDTH];
   endfunction

   function automatic int sel_of(input logic [NCH-1:0] s);
      int n;
      int idx;
      n   = 0;
      idx = 0;
      for (int i = 0; i < NCH; i++)
         if (s[i]) begin
            n++;
            idx = i;
         end
      return (n == 1) ? idx : 0;
   endfunction

   task automatic model_reset();
      m_ch  = 0;
      m_cnt = 0;
      m_res = '0;
      m_upd = 1'b0;
   endtask

   // Advance one clock, step the model with the inputs present at the edge, then compare.
   task automatic cyc(input string tag);
      int nch;
      @(posedge clk);
      if (bus.HOLD) begin
         m_upd = 1'b0;
      end else begin
         if (bus.MODE == 1'b0) begin
            nch   = sel_of(bus.SLCT);
            m_cnt = 0;
         end else if (m_cnt == DWELL - 1) begin
            nch   = (m_ch + 1) % NCH;
            m_cnt = 0;
         end else begin
            nch   = m_ch;
            m_cnt = m_cnt + 1;
         end
         m_upd = (nch != m_ch);
         m_ch  = nch;
         m_res = chan_of(m_ch);
      end
      #1;
      chk({tag, "_result"}, bus.Result, m_res);
      chk({tag, "_ch"},     32'(bus.CH), 32'(m_ch));
      chk({tag, "_update"}, 32'(bus.Update), 32'(m_upd));
   endtask

   task automatic rand_din();
      logic [NCH*WIDTH-1:0] d;
      for (int i = 0; i < NCH; i++)
         d[i*WIDTH +: WIDTH] = $urandom;
      bus.DIN = d;
   endtask

   initial begin
      logic [NCH*WIDTH-1:0] d;
      int c0;
      bus.SLCT = '0;
      bus.MODE = 1'b0;
      bus.HOLD = 1'b0;
      bus.DIN  = '0;
`ifdef DISP_SNAPSHOT_EN
      bus.SNAP = 1'b0;
`endif
      model_reset();
      #1;
      chk("reset_result", bus.Result, 32'h0);
      chk("reset_ch",     32'(bus.CH), 32'h0);
      chk("reset_update", 32'(bus.Update), 32'h0);
      #10;
      rst = 1'b1;
      #2;

      // Manual select of channel 2.
      rand_din();
      d = bus.DIN;
      d[2*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
      bus.DIN  = d;
      bus.SLCT = 5'b00100;
      cyc("man2");
      chk("man2_const_result", bus.Result, 32'hDEAD_BEEF);
      chk("man2_const_update", 32'(bus.Update), 32'h1);
      cyc("man2_stay");

      // Empty and multi-hot selects fall back to channel 0; only the first change pulses.
      bus.SLCT = 5'b00000;
      cyc("sel_zero");
      chk("sel_zero_ch", 32'(bus.CH), 32'h0);
      bus.SLCT = 5'b10010;
      cyc("sel_multi");
      chk("sel_multi_upd", 32'(bus.Update), 32'h0);

      // Auto-scan from channel 3, including the 4 -> 0 wrap.
      bus.SLCT = 5'b01000;
      cyc("pre_scan");
      bus.MODE = 1'b1;
      for (int k = 0; k < 4 * DWELL; k++) begin
         rand_din();
         cyc("scan");
      end
      chk("scan_end_ch", 32'(bus.CH), 32'h2);

      // Hold mid-dwell for 10 cycles with changing data.
      cyc("scan_pre_hold");
      cyc("scan_pre_hold");
      bus.HOLD = 1'b1;
      c0 = int'(bus.CH);
      for (int k = 0; k < 10; k++) begin
         rand_din();
         bus.SLCT = 5'($urandom);
         bus.MODE = 1'($urandom);
         cyc("hold");
      end
      chk("hold_ch_const", 32'(bus.CH), 32'(c0));
      bus.HOLD = 1'b0;
      bus.MODE = 1'b1;
      for (int k = 0; k < 2 * DWELL; k++) cyc("post_hold");

      // Asynchronous reset between edges during auto-scan.
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk("async_rst_result", bus.Result, 32'h0);
      chk("async_rst_ch",     32'(bus.CH), 32'h0);
      chk("async_rst_update", 32'(bus.Update), 32'h0);
      #10;
      rst = 1'b1;
      for (int k = 0; k < 2 * DWELL + 1; k++) begin
         rand_din();
         cyc("scan_after_rst");
      end

      // Randomized mix of modes, selects, holds and data.
      for (int k = 0; k < 300; k++) begin
         rand_din();
         bus.MODE = ($urandom_range(0, 9) < 6);
         bus.HOLD = ($urandom_range(0, 9) < 2);
         if ($urandom_range(0, 1) == 0)
            bus.SLCT = 5'(1 << $urandom_range(0, NCH - 1));
         else
            bus.SLCT = 5'($urandom);
         cyc("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
